// File: rtl/mc_controller_v2.sv
// mc_controller_v2: multi-cycle MIPS-subset control FSM with memory handshake, timeout, exceptions and retire counter
module mc_controller_v2 #(
  parameter int TIMEOUT_W = 8,
  parameter bit EN_TIMEOUT = 1'b1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             IRWrite,
  output logic             MDRWrite,
  output logic             RegWrite,
  output logic             ExtOp,
  output logic             LuiOp,
  output logic             EPCWrite,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       RegDst,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [3:0]       ALUOp,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_EXC} state_t;
  state_t state, nxt;
  logic [TIMEOUT_W-1:0] wcnt;
  logic is_r, is_j, is_jal, is_beq, is_lw, is_sw, is_andi, is_lui, is_slt, is_imm, legal, shift;
  logic mem_st, timeout, retire;
  assign is_r    = OpCode == 6'h00;
  assign is_j    = OpCode == 6'h02;
  assign is_jal  = OpCode == 6'h03;
  assign is_beq  = OpCode == 6'h04;
  assign is_andi = OpCode == 6'h0c;
  assign is_lui  = OpCode == 6'h0f;
  assign is_lw   = OpCode == 6'h23;
  assign is_sw   = OpCode == 6'h2b;
  assign is_slt  = OpCode inside {6'h0a, 6'h0b};
  assign is_imm  = OpCode inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f};
  assign legal   = is_r | is_j | is_jal | is_beq | is_imm | is_lw | is_sw;
  assign shift   = Funct inside {6'h00, 6'h02, 6'h03};
  assign mem_st  = state == S_IF || state == S_MEM;
  assign timeout = EN_TIMEOUT && mem_st && !mem_ready && (&wcnt);
  assign retire  = state == S_WB || (state == S_EX && (is_j || is_beq)) ||
                   (state == S_MEM && is_sw && mem_ready);
  always_comb begin
    {PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, MDRWrite, RegWrite, ExtOp, LuiOp, EPCWrite} = '0;
    {MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource} = '0;
    ALUOp = '0;
    nxt = state;
    if (!reset) begin
      ALUOp = {OpCode[0], (state inside {S_IF, S_ID, S_EXC}) ? 3'b000 : is_r ? 3'b010 :
               is_beq ? 3'b001 : is_andi ? 3'b100 : is_slt ? 3'b101 : 3'b000};
      case (state)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          nxt = mem_ready ? S_ID : timeout ? S_EXC : S_IF;
        end
        S_ID: begin
          ALUSrcB = 2'b11;
          nxt = legal ? S_EX : S_EXC;
        end
        S_EX: begin
          PCWrite = is_j | is_jal;
          PCWriteCond = is_beq;
          PCSource = (is_j | is_jal) ? 2'b10 : is_beq ? 2'b01 : 2'b00;
          ALUSrcA = (is_j | is_jal) ? 2'b00 : (is_r && shift) ? 2'b10 : 2'b01;
          ALUSrcB = (is_lw | is_sw | is_imm) ? 2'b10 : 2'b00;
          ExtOp = is_imm && !is_andi;
          LuiOp = is_lui;
          nxt = (is_j | is_beq) ? S_IF : (is_lw | is_sw) ? S_MEM : S_WB;
        end
        S_MEM: begin
          IorD = 1'b1;
          MemRead = is_lw;
          MemWrite = is_sw && !timeout;
          MDRWrite = is_lw && mem_ready;
          nxt = mem_ready ? (is_lw ? S_WB : S_IF) : timeout ? S_EXC : S_MEM;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst = is_jal ? 2'b10 : (is_r | is_lw) ? 2'b01 : 2'b00;
          MemtoReg = is_jal ? 2'b10 : is_lw ? 2'b01 : 2'b00;
          nxt = S_IF;
        end
        S_EXC: begin
          EPCWrite = 1'b1;
          PCWrite = 1'b1;
          PCSource = 2'b11;
          nxt = S_IF;
        end
        default: nxt = S_IF;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IF;
      wcnt <= '0;
      instret <= '0;
      exc_cause <= 2'b00;
    end else begin
      state <= nxt;
      wcnt <= (mem_st && !mem_ready) ? wcnt + 1'b1 : '0;
      instret <= instret + CNT_W'(retire);
      if (nxt == S_EXC && state != S_EXC) exc_cause <= (state == S_ID) ? 2'b01 : 2'b10;
    end
  end
endmodule
